// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register. When the holding
// register is loaded before the current word ends, words stream back to back.
module bit_serializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     abort,
    output logic                     ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     word_done,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     drop
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             drop_q, drop_d;
    logic             reload, advance;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        word_done_d = word_done_q;
        idx_d       = idx_q;
        drop_d      = 1'b0;
        reload      = 1'b0;
        advance     = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            hold_full_d = 1'b0;
            shreg_d     = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            word_done_d = 1'b0;
            idx_d       = '0;
        end else begin
            drop_d = load && hold_full_q;

            case (state_q)
                ST_IDLE: begin
                    ser_valid_d = 1'b0;
                    ser_out_d   = 1'b0;
                    word_done_d = 1'b0;
                    idx_d       = '0;
                    reload      = hold_full_q;
                end
                default: begin
                    if (idx_q == LAST_IDX) begin
                        if (hold_full_q) begin
                            reload = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            ser_valid_d = 1'b0;
                            ser_out_d   = 1'b0;
                            word_done_d = 1'b0;
                            idx_d       = '0;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            endcase

            // Both paths present the bit that lands at the output end of the shifter.
            if (reload) begin
                state_d     = ST_SHIFT;
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
                ser_valid_d = 1'b1;
                word_done_d = 1'b0;
                idx_d       = '0;
            end
            if (advance) begin
                shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                idx_d       = idx_q + 1'b1;
                word_done_d = ((idx_q + 1'b1) == LAST_IDX);
            end
            if (reload || advance) begin
                ser_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
            end

            // Accept only into an empty holding register; cannot coincide with reload.
            if (load && !hold_full_q) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            idx_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
            idx_q       <= idx_d;
            drop_q      <= drop_d;
        end
    end

    assign ready     = ~hold_full_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign bit_idx   = idx_q;
    assign drop      = drop_q;

endmodule
